// File: rtl/usb_ep_pkg.sv
// Shared types and configuration helpers for the bulk IN endpoint.
// Holds the FSM state encoding, PID toggle values and parameter legality check.
package usb_ep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_HS = 2'd2
  } ep_state_e;

  localparam logic DATA0 = 1'b0;
  localparam logic DATA1 = 1'b1;

  localparam int unsigned MPS_LEGAL [4] = '{8, 16, 32, 64};

  // FIFO must hold two full packets so the app can refill while one is in flight.
  function automatic bit depth_ok(input int unsigned depth, input int unsigned mps);
    bit mps_ok;
    mps_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (MPS_LEGAL[i] == mps) mps_ok = 1'b1;
    end
    return mps_ok && (depth != 0) && ((depth & (depth - 1)) == 0) && (depth >= 2 * mps);
  endfunction

endpackage

// File: rtl/usb_ep_ram.sv
// Simple dual-port byte RAM for the endpoint FIFO.
// Read address is registered, data comes out combinationally from the held address.
module usb_ep_ram
  import usb_ep_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_addr;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd_addr <= '0;
    else       r_rd_addr <= i_rd_addr;
  end

  assign o_rd_data = r_mem[r_rd_addr];

endmodule

// File: rtl/usb_bulk_in_ep.sv
// Bulk IN endpoint: byte FIFO with packetiser, ZLP insertion, DATA0/1 toggle and
// checkpointed retransmission on handshake timeout.
module usb_bulk_in_ep
  import usb_ep_pkg::*;
#(
  parameter int DEPTH           = 32,
  parameter int MAX_PACKET_SIZE = 8,
  parameter bit ZLP_EN          = 1'b1
) (
  input  logic                   clk,
  input  logic                   RSTB,
  input  logic                   clear,
  input  logic [7:0]             app_data,
  input  logic                   app_valid,
  output logic                   app_ready,
  input  logic                   in_req,
  output logic                   in_nak,
  output logic [7:0]             in_data,
  output logic                   in_valid,
  input  logic                   in_ready,
  output logic                   in_last,
  output logic                   in_zlp,
  output logic                   in_toggle,
  input  logic                   in_ack,
  input  logic                   in_timeout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] MPS  = PW'(MAX_PACKET_SIZE);
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  if (!depth_ok(DEPTH, MAX_PACKET_SIZE)) begin : g_bad_cfg
    $error("usb_bulk_in_ep: illegal DEPTH / MAX_PACKET_SIZE combination");
  end

  ep_state_e     r_state, w_state_nxt;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_ckpt_ptr;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_ckpt_nxt;
  logic [PW-1:0] r_pkt_len, r_cnt, w_pkt_len_nxt, w_cnt_nxt;
  logic          r_toggle, w_toggle_nxt;
  logic          r_zlp_pending, w_zlp_nxt;
  logic          r_nak, w_nak_nxt;
  logic [PW-1:0] w_avail;
  logic          w_wr_en, w_last_beat, w_is_zlp;
  logic [7:0]    w_rd_data;

  assign level     = r_wr_ptr - r_ckpt_ptr;
  assign w_avail   = r_wr_ptr - r_rd_ptr;
  assign app_ready = (level != FULL);
  assign w_wr_en   = app_valid && app_ready && !clear;
  assign in_nak    = r_nak;
  assign in_toggle = r_toggle;
  assign in_data   = w_rd_data;

  assign w_is_zlp    = (r_pkt_len == '0);
  assign w_last_beat = w_is_zlp || (r_cnt == r_pkt_len - PW'(1));

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_nxt      = r_wr_ptr + PW'(w_wr_en);
    w_rd_nxt      = r_rd_ptr;
    w_ckpt_nxt    = r_ckpt_ptr;
    w_pkt_len_nxt = r_pkt_len;
    w_cnt_nxt     = r_cnt;
    w_toggle_nxt  = r_toggle;
    w_zlp_nxt     = r_zlp_pending && !w_wr_en;  // fresh data supersedes a pending ZLP
    w_nak_nxt     = 1'b0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_zlp        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (in_req) begin
          if (w_avail != '0) begin
            w_pkt_len_nxt = (w_avail > MPS) ? MPS : w_avail;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_SEND;
          end else if (r_zlp_pending) begin
            w_pkt_len_nxt = '0;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_SEND;
          end else begin
            w_nak_nxt = 1'b1;
          end
        end
      end
      ST_SEND: begin
        in_valid = 1'b1;
        in_zlp   = w_is_zlp;
        in_last  = w_last_beat;
        if (in_ready) begin
          if (!w_is_zlp) begin
            w_rd_nxt  = r_rd_ptr + PW'(1);
            w_cnt_nxt = r_cnt + PW'(1);
          end
          if (w_last_beat) w_state_nxt = ST_WAIT_HS;
        end
      end
      ST_WAIT_HS: begin
        if (in_ack) begin
          w_ckpt_nxt   = r_rd_ptr;
          w_toggle_nxt = (r_toggle == DATA0) ? DATA1 : DATA0;
          w_zlp_nxt    = ZLP_EN && (r_pkt_len == MPS) && (w_avail == '0) && !w_wr_en;
          w_state_nxt  = ST_IDLE;
        end else if (in_timeout) begin
          w_rd_nxt    = r_ckpt_ptr;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (clear) begin
      w_state_nxt   = ST_IDLE;
      w_wr_nxt      = '0;
      w_rd_nxt      = '0;
      w_ckpt_nxt    = '0;
      w_pkt_len_nxt = '0;
      w_cnt_nxt     = '0;
      w_toggle_nxt  = DATA0;
      w_zlp_nxt     = 1'b0;
      w_nak_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RSTB) begin
    if (RSTB) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ckpt_ptr    <= '0;
      r_pkt_len     <= '0;
      r_cnt         <= '0;
      r_toggle      <= DATA0;
      r_zlp_pending <= 1'b0;
      r_nak         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_nxt;
      r_rd_ptr      <= w_rd_nxt;
      r_ckpt_ptr    <= w_ckpt_nxt;
      r_pkt_len     <= w_pkt_len_nxt;
      r_cnt         <= w_cnt_nxt;
      r_toggle      <= w_toggle_nxt;
      r_zlp_pending <= w_zlp_nxt;
      r_nak         <= w_nak_nxt;
    end
  end

  // Feeding the next read pointer keeps in_data aligned with rd_ptr every cycle.
  usb_ep_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (clk),
    .i_rst     (RSTB),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (app_data),
    .i_rd_addr (w_rd_nxt[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

endmodule

// File: tb/tb_usb_bulk_in_ep.sv
// Self-checking bench for usb_bulk_in_ep: queue-based packet model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_usb_bulk_in_ep;

  localparam int DEPTH  = 32;
  localparam int MPS    = 8;
  localparam bit ZLP_EN = 1'b1;

  logic       clk = 1'b0;
  logic       RSTB = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] app_data = '0;
  logic       app_valid = 1'b0;
  logic       app_ready;
  logic       in_req = 1'b0;
  logic       in_nak;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready = 1'b1;
  logic       in_last;
  logic       in_zlp;
  logic       in_toggle;
  logic       in_ack = 1'b0;
  logic       in_timeout = 1'b0;
  logic [5:0] level;

  int checks = 0;
  int errors = 0;

  usb_bulk_in_ep #(
    .DEPTH           (DEPTH),
    .MAX_PACKET_SIZE (MPS),
    .ZLP_EN          (ZLP_EN)
  ) dut (
    .clk        (clk),
    .RSTB       (RSTB),
    .clear      (clear),
    .app_data   (app_data),
    .app_valid  (app_valid),
    .app_ready  (app_ready),
    .in_req     (in_req),
    .in_nak     (in_nak),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_zlp     (in_zlp),
    .in_toggle  (in_toggle),
    .in_ack     (in_ack),
    .in_timeout (in_timeout),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mq holds every unacknowledged byte; the in-flight packet is its head.
  logic [7:0] mq[$];
  int m_phase = 0;  // 0 idle, 1 sending, 2 awaiting handshake
  int m_pkt = 0;
  int m_sent = 0;
  int m_tog = 0;
  int m_zp = 0;
  int m_nak = 0;

  always @(posedge clk) begin
    int  avail, nak_n, zp_n;
    bit  wr;
    if (RSTB || clear) begin
      mq.delete();
      m_phase = 0; m_pkt = 0; m_sent = 0; m_tog = 0; m_zp = 0; m_nak = 0;
    end else begin
      wr    = app_valid && (mq.size() != DEPTH);
      avail = mq.size() - m_sent;
      nak_n = 0;
      zp_n  = m_zp && !wr;
      case (m_phase)
        0: if (in_req) begin
             if (avail > 0) begin
               m_pkt = (avail > MPS) ? MPS : avail; m_sent = 0; m_phase = 1;
             end else if (m_zp != 0) begin
               m_pkt = 0; m_sent = 0; m_phase = 1;
             end else nak_n = 1;
           end
        1: if (in_ready) begin
             if (m_pkt == 0) m_phase = 2;
             else begin
               m_sent++;
               if (m_sent == m_pkt) m_phase = 2;
             end
           end
        default: if (in_ack) begin
             for (int i = 0; i < m_pkt; i++) void'(mq.pop_front());
             zp_n    = (ZLP_EN && m_pkt == MPS && avail == 0 && !wr) ? 1 : 0;
             m_tog   = 1 - m_tog;
             m_sent  = 0;
             m_phase = 0;
           end else if (in_timeout) begin
             m_sent  = 0;
             m_phase = 0;
           end
      endcase
      if (wr) mq.push_back(app_data);
      m_nak = nak_n;
      m_zp  = zp_n;
    end
  end

  always @(negedge clk) begin
    if (!RSTB) begin
      chk("app_ready", app_ready, mq.size() != DEPTH);
      chk("level", level, mq.size());
      chk("in_nak", in_nak, m_nak);
      chk("in_valid", in_valid, m_phase == 1);
      chk("in_toggle", in_toggle, m_tog);
      if (m_phase == 1) begin
        chk("in_zlp", in_zlp, m_pkt == 0);
        chk("in_last", in_last, (m_pkt == 0) || (m_sent == m_pkt - 1));
        if (m_pkt != 0) chk("in_data", in_data, mq[m_sent]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    app_data  = b;
    app_valid = 1'b1;
    tick();
    app_valid = 1'b0;
  endtask

  logic [7:0] got[$];
  bit got_zlp, got_nak, got_tog;

  task automatic get_pkt();
    bit done;
    done = 0;
    got.delete(); got_zlp = 0; got_nak = 0; got_tog = 0;
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    if (in_nak) begin
      got_nak = 1;
      return;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      if (in_valid && in_ready) begin
        got_tog = in_toggle;
        if (in_zlp) got_zlp = 1;
        else got.push_back(in_data);
        if (in_last) done = 1;
      end
      tick();
    end
    chk("pkt_done", done, 1);
  endtask

  task automatic pulse_ack();
    in_ack = 1'b1; tick(); in_ack = 1'b0;
  endtask

  task automatic chk_pkt(input string name, input int base, input int n, input int tog);
    chk({name, "_nak"}, got_nak, 0);
    chk({name, "_len"}, got.size(), n);
    chk({name, "_tog"}, got_tog, tog);
    for (int i = 0; i < n && i < got.size(); i++) chk({name, "_byte"}, got[i], (base + i) & 8'hff);
  endtask

  initial begin
    int acc;
    repeat (3) @(posedge clk);
    #1 RSTB = 1'b0;
    tick();
    chk("rst_level", level, 0);
    chk("rst_ready", app_ready, 1);
    chk("rst_valid", in_valid, 0);
    chk("rst_toggle", in_toggle, 0);

    // 7-byte short packet, then NAK
    for (int i = 1; i <= 7; i++) wr_byte(8'(i));
    get_pkt();
    chk_pkt("p7", 1, 7, 0);
    pulse_ack();
    chk("p7_level", level, 0);
    get_pkt();
    chk("p7_nak", got_nak, 1);

    // full packet that empties the FIFO -> ZLP
    for (int i = 0; i < 8; i++) wr_byte(8'(8'h11 + i));
    get_pkt();
    chk_pkt("p8", 8'h11, 8, 1);
    pulse_ack();
    get_pkt();
    chk("zlp1_flag", got_zlp, 1);
    chk("zlp1_len", got.size(), 0);
    chk("zlp1_tog", got_tog, 0);
    pulse_ack();
    get_pkt();
    chk("zlp1_nak", got_nak, 1);

    // 16 bytes -> 8, 8, ZLP
    for (int i = 0; i < 8; i++) wr_byte(8'(8'h21 + i));
    for (int i = 0; i < 8; i++) wr_byte(8'(8'h32 + i));
    get_pkt(); chk_pkt("p16a", 8'h21, 8, 1); pulse_ack();
    get_pkt(); chk_pkt("p16b", 8'h32, 8, 0); pulse_ack();
    get_pkt();
    chk("zlp2_flag", got_zlp, 1);
    chk("zlp2_tog", got_tog, 1);
    pulse_ack();

    // timeout -> identical resend with same PID
    for (int i = 1; i <= 7; i++) wr_byte(8'(i));
    get_pkt(); chk_pkt("to_first", 1, 7, 0);
    in_timeout = 1'b1; tick(); in_timeout = 1'b0;
    chk("to_level", level, 7);
    get_pkt(); chk_pkt("to_resend", 1, 7, 0);
    pulse_ack();
    chk("to_toggle", in_toggle, 1);

    // fill to DEPTH
    acc = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      app_data = 8'(i); app_valid = 1'b1;
      if (app_ready) acc++;
      tick();
    end
    app_valid = 1'b0;
    chk("fill_acc", acc, 32);
    chk("fill_level", level, 32);
    chk("fill_ready", app_ready, 0);
    get_pkt(); chk_pkt("fill_pkt", 0, 8, 1);
    pulse_ack();
    chk("fill_ready_after", app_ready, 1);
    chk("fill_level_after", level, 24);
    get_pkt(); chk_pkt("fill_pkt2", 8, 8, 0);
    pulse_ack();

    // clear mid-SEND after three accepted bytes
    in_req = 1'b1; tick(); in_req = 1'b0;
    tick(); tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_valid", in_valid, 0);
    chk("clr_level", level, 0);
    chk("clr_toggle", in_toggle, 0);
    get_pkt();
    chk("clr_nak", got_nak, 1);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      app_valid  = ($urandom_range(0, 99) < 55);
      app_data   = 8'($urandom);
      in_ready   = ($urandom_range(0, 99) < 75);
      in_req     = ($urandom_range(0, 99) < 15);
      in_ack     = ($urandom_range(0, 99) < 20);
      in_timeout = ($urandom_range(0, 99) < 8);
      clear      = ($urandom_range(0, 999) < 4);
      tick();
    end
    app_valid = 0; in_req = 0; in_ack = 0; in_timeout = 0; clear = 0; in_ready = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
